// File: rtl/switch_alloc_5p.sv
// rtl/switch_alloc_5p.sv - separable round-robin switch allocator with packet locking for a 5-port router
module switch_alloc_5p #(
    parameter int NUM_PORT     = 5,
    parameter int LOG_NUM_PORT = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORT*NUM_PORT-1:0] reqVector,
    input  logic [NUM_PORT-1:0]          tailIn,
    input  logic [NUM_PORT-1:0]          outReady,
    output logic [NUM_PORT*NUM_PORT-1:0] allocVector,
    output logic [NUM_PORT-1:0]          grantIn,
    output logic [NUM_PORT-1:0]          outValid
);

    localparam logic [NUM_PORT-1:0]     ROW_ONE  = NUM_PORT'(1);
    localparam logic [LOG_NUM_PORT-1:0] IDX_ONE  = LOG_NUM_PORT'(1);
    localparam logic [LOG_NUM_PORT-1:0] IDX_LAST = LOG_NUM_PORT'(NUM_PORT - 1);

    // Per-output arbitration state
    logic [LOG_NUM_PORT-1:0]      ptr   [NUM_PORT];
    logic [LOG_NUM_PORT-1:0]      owner [NUM_PORT];
    logic [NUM_PORT-1:0]          lock;

    // Combinational allocation results for the current cycle
    logic [NUM_PORT-1:0]          req_oh  [NUM_PORT];
    logic [NUM_PORT-1:0]          gnt_valid;
    logic [LOG_NUM_PORT-1:0]      gnt_idx [NUM_PORT];
    logic [NUM_PORT*NUM_PORT-1:0] alloc_next;
    logic [NUM_PORT-1:0]          grant_next;

    // Keep only the lowest-index output bit of each input's request row
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            req_oh[i] = reqVector[i*NUM_PORT +: NUM_PORT]
                      & (~reqVector[i*NUM_PORT +: NUM_PORT] + ROW_ONE);
        end
    end

    // Per-output search starting at ptr[o]; a locked output only considers its owner
    always_comb begin
        logic [LOG_NUM_PORT-1:0] idx;
        idx = '0;
        for (int o = 0; o < NUM_PORT; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_idx[o]   = '0;
            for (int k = 0; k < NUM_PORT; k++) begin
                idx = LOG_NUM_PORT'((int'(ptr[o]) + k) % NUM_PORT);
                if (!gnt_valid[o] && outReady[o] && req_oh[idx][o]
                    && (!lock[o] || (idx == owner[o]))) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = idx;
                end
            end
        end
    end

    // Expand per-output winners into the crossbar matrix and per-input dequeue strobes
    always_comb begin
        alloc_next = '0;
        grant_next = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                alloc_next[i*NUM_PORT+o] = gnt_valid[o] && (gnt_idx[o] == LOG_NUM_PORT'(i));
            end
        end
        for (int i = 0; i < NUM_PORT; i++) begin
            grant_next[i] = |alloc_next[i*NUM_PORT +: NUM_PORT];
        end
    end

    // Register grants and advance pointer/lock state; a tail releases the output and rotates priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            allocVector <= '0;
            grantIn     <= '0;
            outValid    <= '0;
            lock        <= '0;
            for (int o = 0; o < NUM_PORT; o++) begin
                ptr[o]   <= '0;
                owner[o] <= '0;
            end
        end else begin
            allocVector <= alloc_next;
            grantIn     <= grant_next;
            outValid    <= gnt_valid;
            for (int o = 0; o < NUM_PORT; o++) begin
                if (gnt_valid[o]) begin
                    if (tailIn[gnt_idx[o]]) begin
                        lock[o] <= 1'b0;
                        ptr[o]  <= (gnt_idx[o] == IDX_LAST) ? '0 : gnt_idx[o] + IDX_ONE;
                    end else begin
                        lock[o]  <= 1'b1;
                        owner[o] <= gnt_idx[o];
                    end
                end
            end
        end
    end

endmodule
